shared_gfn_mulsqsc_dom: RTL and testbench

Parametrised, masked GF(2^N) multiplier using domain-oriented masking (DOM), for the tower-field inverter of the masked AES S-box. It computes Q = X*B, and optionally adds square-scale(X^Y), over SHARES Boolean shares. It adds three things the previous GF(2^2)-only block lacks: a runtime mode select, a valid handshake with register-enable, and a selectable pipeline depth. It sits in the GF(2^4) / GF(2^2) inversion stages and replaces the fixed-width fused block.

---
 rtl/shared_gfn_mulsqsc_dom_pkg.sv | 52 +++++
 rtl/shared_gfn_mulsqsc_dom_gfn_mul.sv | 18 +
 rtl/shared_gfn_mulsqsc_dom.sv | 125 ++++++++++++
 tb/tb_shared_gfn_mulsqsc_dom.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_gfn_mulsqsc_dom_pkg.sv
// Field helpers for the masked tower-field inverter datapath.
// All elements are in normal basis; GF(2^2) uses basis (W^2, W), so one = 2'b11.
// GF(2^4) elements are {Ah, Al} over GF(2^2) with normal basis (Z^4, Z).
package gf_mask_pkg;

    // Width of the cross-term randomness bus: one N-bit mask per unordered share pair.
    function automatic int unsigned ZW(input int unsigned n, input int unsigned shares);
        return n * shares * (shares - 1) / 2;
    endfunction

    // Randomness index of pair (k,l), k<l; the transposed term reuses it.
    function automatic int unsigned zidx(input int unsigned k, input int unsigned l);
        return k + l * (l - 1) / 2;
    endfunction

    // GF(2^2) normal-basis multiply.
    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

    // GF(2^2) squaring is a bit swap in normal basis.
    function automatic logic [1:0] sq2(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    function automatic logic [1:0] sqsc2(input logic [1:0] a);
        return {a[0], a[1] ^ a[0]};
    endfunction

    // Multiply by the tower constant N = W^2 (2'b10).
    function automatic logic [1:0] scl_n2(input logic [1:0] a);
        return {a[0], a[1] ^ a[0]};
    endfunction

    // GF(2^4) tower multiply: shared middle term scaled by N.
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] e;
        logic [1:0] ph;
        logic [1:0] pl;
        e  = scl_n2(gf2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        ph = gf2_mul(a[3:2], b[3:2]) ^ e;
        pl = gf2_mul(a[1:0], b[1:0]) ^ e;
        return {ph, pl};
    endfunction

    function automatic logic [3:0] sqsc4(input logic [3:0] a);
        return {sq2(a[3:2] ^ a[1:0]), sqsc2(sq2(a[1:0]))};
    endfunction

endpackage

// File: rtl/shared_gfn_mulsqsc_dom_gfn_mul.sv
// Combinational GF(2^N) multiplier, N = 2 or 4, one instance per share product.
module gfn_mul
    import gf_mask_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_q
);

    if (N == 2) begin : g_gf2
        assign o_q = gf2_mul(i_a, i_b);
    end else begin : g_gf4
        assign o_q = gf4_mul(i_a, i_b);
    end

endmodule

// File: rtl/shared_gfn_mulsqsc_dom.sv
// DOM-masked GF(2^N) multiplier with optional square-scale addend:
// Q = X*B (mode 0) or X*B ^ sqsc(X^Y) (mode 1), over SHARES Boolean shares.
// Every share product is registered before compression so no unregistered
// cross-domain term reaches the output.
module shared_gfn_mulsqsc_dom
    import gf_mask_pkg::*;
#(
    parameter int unsigned N         = 2,
    parameter int unsigned SHARES    = 2,
    parameter int unsigned PIPELINED = 1
) (
    input  logic                        ClkxCI,
    input  logic                        RstxBI,
    input  logic                        ValidxSI,
    input  logic                        ModexSI,
    input  logic [N*SHARES-1:0]         XxDI,
    input  logic [N*SHARES-1:0]         BxDI,
    input  logic [N*SHARES-1:0]         YxDI,
    input  logic [ZW(N, SHARES)-1:0]    ZxDI,
    output logic [N*SHARES-1:0]         QxDO,
    output logic                        ValidxSO
);

    if (!(N == 2 || N == 4)) begin : g_bad_n
        $error("shared_gfn_mulsqsc_dom: N must be 2 or 4");
    end
    if (SHARES < 2) begin : g_bad_shares
        $error("shared_gfn_mulsqsc_dom: SHARES must be at least 2");
    end
    if (!(PIPELINED == 1 || PIPELINED == 2)) begin : g_bad_pipe
        $error("shared_gfn_mulsqsc_dom: PIPELINED must be 1 or 2");
    end

    logic [N-1:0]        w_prod   [SHARES][SHARES];
    logic [N-1:0]        w_ff_d   [SHARES][SHARES];
    logic [N-1:0]        r_ff     [SHARES][SHARES];
    logic [N-1:0]        w_sqsc_m [SHARES];
    logic [N*SHARES-1:0] w_q;
    logic                r_valid1;

    // Per-domain square-scale term, gated by mode before it reaches the flops.
    for (genvar i = 0; i < SHARES; i++) begin : g_sq
        logic [N-1:0] w_xy;
        logic [N-1:0] w_sqsc;
        assign w_xy = XxDI[i*N +: N] ^ YxDI[i*N +: N];
        if (N == 2) begin : g_n2
            assign w_sqsc = sqsc2(w_xy);
        end else begin : g_n4
            assign w_sqsc = sqsc4(w_xy);
        end
        assign w_sqsc_m[i] = ModexSI ? w_sqsc : '0;
    end

    // Share products; cross-domain terms are blinded by fresh Z before registering.
    for (genvar i = 0; i < SHARES; i++) begin : g_row
        for (genvar j = 0; j < SHARES; j++) begin : g_col
            gfn_mul #(
                .N (N)
            ) u_mul (
                .i_a (XxDI[i*N +: N]),
                .i_b (BxDI[j*N +: N]),
                .o_q (w_prod[i][j])
            );
            if (i == j) begin : g_inner
                assign w_ff_d[i][j] = w_prod[i][j] ^ w_sqsc_m[i];
            end else begin : g_cross
                localparam int unsigned P = (i < j) ? zidx(i, j) : zidx(j, i);
                assign w_ff_d[i][j] = w_prod[i][j] ^ ZxDI[P*N +: N];
            end
        end
    end

    // DOM register stage: loads only on valid, otherwise holds.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_ff <= '{default: '0};
        end else if (ValidxSI) begin
            r_ff <= w_ff_d;
        end
    end

    // Stage-1 valid tracks the input valid every cycle.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_valid1 <= 1'b0;
        end else begin
            r_valid1 <= ValidxSI;
        end
    end

    // Compression: XOR of registered terms only.
    always_comb begin
        w_q = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                w_q[i*N +: N] = w_q[i*N +: N] ^ r_ff[i][j];
            end
        end
    end

    if (PIPELINED == 1) begin : g_pipe1
        assign QxDO     = w_q;
        assign ValidxSO = r_valid1;
    end else begin : g_pipe2
        logic [N*SHARES-1:0] r_q;
        logic                r_valid2;

        // Output register: captures compressed shares when stage 1 holds a new result.
        always_ff @(posedge ClkxCI or negedge RstxBI) begin
            if (!RstxBI) begin
                r_q      <= '0;
                r_valid2 <= 1'b0;
            end else begin
                r_valid2 <= r_valid1;
                if (r_valid1) begin
                    r_q <= w_q;
                end
            end
        end

        assign QxDO     = r_q;
        assign ValidxSO = r_valid2;
    end

endmodule

// File: tb/tb_shared_gfn_mulsqsc_dom.sv
// Bench for shared_gfn_mulsqsc_dom: two instances (N=2/SHARES=2/1-cycle and
// N=4/SHARES=3/2-cycle), expected unmasked results queued at issue and
// compared by per-instance monitors when ValidxSO is due.
module tb_shared_gfn_mulsqsc_dom;

    localparam int NA = 2, SA = 2, PA = 1, WA = NA * SA, ZA = NA * SA * (SA - 1) / 2;
    localparam int NB = 4, SB = 3, PB = 2, WB = NB * SB, ZB = NB * SB * (SB - 1) / 2;

    typedef logic [WA-1:0] wa_t;
    typedef logic [ZA-1:0] za_t;
    typedef logic [WB-1:0] wb_t;
    typedef logic [ZB-1:0] zb_t;
    typedef struct {
        logic [3:0] val;
        int         due;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic va_i, ma_i, va_o;
    wa_t  xa, ba, ya, qa;
    za_t  za;
    logic vb_i, mb_i, vb_o;
    wb_t  xb, bb, yb, qb;
    zb_t  zb;

    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    ent_t       sb_a[$];
    ent_t       sb_b[$];
    logic [1:0] last_a;
    logic [3:0] last_b;

    shared_gfn_mulsqsc_dom #(.N(NA), .SHARES(SA), .PIPELINED(PA)) u_dut_a (
        .ClkxCI   (clk),
        .RstxBI   (rst_n),
        .ValidxSI (va_i),
        .ModexSI  (ma_i),
        .XxDI     (xa),
        .BxDI     (ba),
        .YxDI     (ya),
        .ZxDI     (za),
        .QxDO     (qa),
        .ValidxSO (va_o)
    );

    shared_gfn_mulsqsc_dom #(.N(NB), .SHARES(SB), .PIPELINED(PB)) u_dut_b (
        .ClkxCI   (clk),
        .RstxBI   (rst_n),
        .ValidxSI (vb_i),
        .ModexSI  (mb_i),
        .XxDI     (xb),
        .BxDI     (bb),
        .YxDI     (yb),
        .ZxDI     (zb),
        .QxDO     (qb),
        .ValidxSO (vb_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: GF(2^2) via polynomial basis (1, W), W^2 = W + 1.
    // Normal {a1,a0} = a1*W^2 + a0*W = a1 + (a1^a0)*W.
    function automatic logic [1:0] m_mul2(input logic [1:0] a, input logic [1:0] b);
        logic c0, c1, d0, d1, e0, e1;
        c0 = a[1]; c1 = a[1] ^ a[0];
        d0 = b[1]; d1 = b[1] ^ b[0];
        e0 = (c0 & d0) ^ (c1 & d1);
        e1 = (c0 & d1) ^ (c1 & d0) ^ (c1 & d1);
        return {e0, e1 ^ e0};
    endfunction

    // GF(2^4) = GF(2^2)[Z]/(Z^2 + Z + W^2); normal {Ah,Al} = Ah + (Ah^Al)*Z.
    function automatic logic [3:0] m_mul4(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] c0, c1, d0, d1, e0, e1;
        c0 = a[3:2]; c1 = a[3:2] ^ a[1:0];
        d0 = b[3:2]; d1 = b[3:2] ^ b[1:0];
        e0 = m_mul2(c0, d0) ^ m_mul2(2'b10, m_mul2(c1, d1));
        e1 = m_mul2(c0, d1) ^ m_mul2(c1, d0) ^ m_mul2(c1, d1);
        return {e0, e1 ^ e0};
    endfunction

    function automatic logic [1:0] m_sqsc2(input logic [1:0] a);
        return {a[0], a[1] ^ a[0]};
    endfunction

    function automatic logic [3:0] m_sqsc4(input logic [3:0] a);
        logic [1:0] s, l;
        s = a[3:2] ^ a[1:0];
        l = a[1:0];
        return {s[0], s[1], m_sqsc2({l[0], l[1]})};
    endfunction

    function automatic logic [1:0] unmask_a(input wa_t v);
        return v[1:0] ^ v[3:2];
    endfunction

    function automatic logic [3:0] unmask_b(input wb_t v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic drive_a(input logic v, input logic m, input wa_t x, input wa_t b, input wa_t y,
                           input za_t z, input logic lit_en, input logic [1:0] lit);
        logic [1:0] xu, bu, yu, ex;
        ent_t       e;
        va_i = v; ma_i = m; xa = x; ba = b; ya = y; za = z;
        xu = unmask_a(x); bu = unmask_a(b); yu = unmask_a(y);
        ex = m_mul2(xu, bu) ^ (m ? m_sqsc2(xu ^ yu) : 2'b00);
        if (lit_en) ex = lit;
        if (v) begin
            e.val = {2'b00, ex};
            e.due = cyc + PA;
            sb_a.push_back(e);
            last_a = ex;
        end
    endtask

    task automatic drive_b(input logic v, input logic m, input wb_t x, input wb_t b, input wb_t y,
                           input zb_t z);
        logic [3:0] xu, bu, yu, ex;
        ent_t       e;
        vb_i = v; mb_i = m; xb = x; bb = b; yb = y; zb = z;
        xu = unmask_b(x); bu = unmask_b(b); yu = unmask_b(y);
        ex = m_mul4(xu, bu) ^ (m ? m_sqsc4(xu ^ yu) : 4'h0);
        if (v) begin
            e.val = ex;
            e.due = cyc + PB;
            sb_b.push_back(e);
            last_b = ex;
        end
    endtask

    task automatic rand_a(input logic v, input logic m);
        drive_a(v, m, wa_t'($urandom), wa_t'($urandom), wa_t'($urandom), za_t'($urandom),
                1'b0, 2'b00);
    endtask

    task automatic rand_b(input logic v, input logic m);
        drive_b(v, m, wb_t'($urandom), wb_t'($urandom), wb_t'($urandom), zb_t'($urandom));
    endtask

    // Monitor for instance A.
    initial begin : mon_a
        ent_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (sb_a.size() > 0 && sb_a[0].due <= cyc) begin
                    e = sb_a.pop_front();
                    checks++;
                    if (va_o !== 1'b1) begin
                        errors++;
                        $display("FAIL a_valid: ValidxSO=%b want 1 at cycle %0d", va_o, cyc);
                    end else if ({2'b00, unmask_a(qa)} !== e.val) begin
                        errors++;
                        $display("FAIL a_data: got %h want %h at cycle %0d",
                                 unmask_a(qa), e.val, cyc);
                    end
                end else if (va_o !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_stray_valid: ValidxSO=%b want 0 at cycle %0d", va_o, cyc);
                end
            end
        end
    end

    // Monitor for instance B.
    initial begin : mon_b
        ent_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (sb_b.size() > 0 && sb_b[0].due <= cyc) begin
                    e = sb_b.pop_front();
                    checks++;
                    if (vb_o !== 1'b1) begin
                        errors++;
                        $display("FAIL b_valid: ValidxSO=%b want 1 at cycle %0d", vb_o, cyc);
                    end else if (unmask_b(qb) !== e.val) begin
                        errors++;
                        $display("FAIL b_data: got %h want %h at cycle %0d",
                                 unmask_b(qb), e.val, cyc);
                    end
                end else if (vb_o !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_stray_valid: ValidxSO=%b want 0 at cycle %0d", vb_o, cyc);
                end
            end
        end
    end

    initial begin : main
        drive_a(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 2'b00);
        drive_b(1'b0, 1'b0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        chk("reset_qa", 32'(qa), 32'd0);
        chk("reset_va", 32'(va_o), 32'd0);
        chk("reset_qb", 32'(qb), 32'd0);
        chk("reset_vb", 32'(vb_o), 32'd0);

        // Directed N=2: X=10, B=11, mode 0 -> 10.
        drive_a(1'b1, 1'b0, 4'b1101, 4'b0110, wa_t'($urandom), 2'b10, 1'b1, 2'b10);
        @(negedge clk);
        // Directed N=2: X=00, Y=10, mode 1 -> sqsc2(10) = 01.
        drive_a(1'b1, 1'b1, 4'b0101, wa_t'($urandom), 4'b0111, 2'b11, 1'b1, 2'b01);
        @(negedge clk);
        drive_a(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 2'b00);

        // Back-to-back burst of 4 on the 2-cycle instance.
        for (int k = 0; k < 4; k++) begin
            rand_b(1'b1, 1'(k));
            @(negedge clk);
        end
        rand_b(1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // Operands toggle with valid low: outputs must hold.
        for (int k = 0; k < 6; k++) begin
            rand_a(1'b0, 1'(k));
            rand_b(1'b0, 1'(k));
            @(posedge clk);
            #1;
            chk("hold_qa", 32'(unmask_a(qa)), 32'(last_a));
            chk("hold_qb", 32'(unmask_b(qb)), 32'(last_b));
            chk("hold_va", 32'(va_o), 32'd0);
            chk("hold_vb", 32'(vb_o), 32'd0);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 3; k++) begin
            rand_a(1'b1, 1'(k));
            rand_b(1'b1, 1'(k));
            @(negedge clk);
        end
        rand_a(1'b1, 1'b1);
        rand_b(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_qa", 32'(qa), 32'd0);
        chk("rst_async_va", 32'(va_o), 32'd0);
        chk("rst_async_qb", 32'(qb), 32'd0);
        chk("rst_async_vb", 32'(vb_o), 32'd0);
        sb_a.delete();
        sb_b.delete();
        rand_a(1'b0, 1'b0);
        rand_b(1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_qb", 32'(qb), 32'd0);
        chk("post_rst_vb", 32'(vb_o), 32'd0);

        // Random vectors per mode with fresh Z each cycle and occasional idle gaps.
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 1000; k++) begin
                rand_a(1'($urandom_range(0, 5) != 0), 1'($urandom));
                rand_b(1'($urandom_range(0, 7) != 0), 1'(m));
                @(negedge clk);
            end
        end
        rand_a(1'b0, 1'b0);
        rand_b(1'b0, 1'b0);
        repeat (6) @(negedge clk);

        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending a=%0d b=%0d want 0", sb_a.size(), sb_b.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
